// File: rtl/vip_awb_pkg.sv
// Shared constants, FSM states and sizing helper
// for the gray-world auto white balance stage.
package vip_awb_pkg;

  localparam int UNITY_GAIN = 256;
  localparam int GAIN_MAX   = 1023;

  typedef enum logic [1:0] {
    IDLE,
    DIV_R,
    DIV_B,
    LOAD
  } awb_state_e;

  // Smallest width whose range strictly exceeds a full frame of 255s.
  function automatic int sum_width(
    input int hdisp,
    input int vdisp
  );
    return $clog2(hdisp * vdisp * 255 + 1);
  endfunction

endpackage

// File: rtl/vip_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle,
// with a saturating quotient output.
module vip_seq_divider #(
  parameter int NUM_W = 35,
  parameter int DEN_W = 27,
  parameter int Q_W   = 10,
  parameter int Q_MAX = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q, quo_d, quo_src;
  logic [DEN_W-1:0] rem_q, rem_d, rem_src;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   rem_sh;
  logic             fits;
  logic             ovf;

  // The first iteration runs on the start edge itself.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    den_d   = start ? divisor : den_q;
    rem_sh  = {rem_src, quo_src[NUM_W-1]};
    fits    = rem_sh >= {1'b0, den_d};
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start || busy_q) begin
      rem_d  = fits ? DEN_W'(rem_sh - {1'b0, den_d})
                    : DEN_W'(rem_sh);
      quo_d  = {quo_src[NUM_W-2:0], fits};
      cnt_d  = start ? CW'(1) : cnt_q + CW'(1);
      busy_d = cnt_d != CW'(NUM_W);
      done_d = ~busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign ovf      = (den_q == '0) || (quo_q > NUM_W'(Q_MAX));
  assign quotient = ovf ? Q_W'(Q_MAX) : quo_q[Q_W-1:0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/vip_rgb888_awb_grayworld.sv
// Gray-world AWB: per-frame channel sums give R/B gains
// that are applied to the following frame.
module vip_rgb888_awb_grayworld
  import vip_awb_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int GAIN_FRAC = 8,
  parameter int GAIN_W    = 10,
  parameter int SUM_W     = sum_width(IMG_HDISP, IMG_VDISP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [23:0]       per_img_rgb888,
  input  logic              awb_en,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [23:0]       post_img_rgb888,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_b,
  output logic              gain_valid
);

  localparam int NUM_W = SUM_W + GAIN_FRAC;
  localparam int PW    = 8 + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(UNITY_GAIN);

  awb_state_e state_q, state_d;

  logic [7:0]       pix_r, pix_g, pix_b;
  logic             rise, fall, pix_ok;
  logic             vs1_q, hs1_q, ce1_q;
  logic             vs2_q, hs2_q, ce2_q;
  logic [SUM_W-1:0] sum_r_q, sum_r_d;
  logic [SUM_W-1:0] sum_g_q, sum_g_d;
  logic [SUM_W-1:0] sum_b_q, sum_b_d;
  logic [SUM_W-1:0] snap_g_q, snap_g_d;
  logic [SUM_W-1:0] snap_b_q, snap_b_d;
  logic [GAIN_W-1:0] qr_q, qr_d;
  logic [GAIN_W-1:0] shadow_r_q, shadow_r_d;
  logic [GAIN_W-1:0] shadow_b_q, shadow_b_d;
  logic              pend_q, pend_d;
  logic [GAIN_W-1:0] gain_r_q, gain_r_d;
  logic [GAIN_W-1:0] gain_b_q, gain_b_d;
  logic              gain_valid_q, gain_valid_d;

  logic              div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num;
  logic [SUM_W-1:0]  div_den;
  logic [GAIN_W-1:0] div_q;

  logic [GAIN_W-1:0] gr, gb;
  logic [PW-1:0]     pr_q, pr_d, pb_q, pb_d;
  logic [PW-1:0]     r_sh, b_sh;
  logic [7:0]        r_out, b_out, g1_q;
  logic [23:0]       post_img_q, post_img_d;

  assign pix_r  = per_img_rgb888[23:16];
  assign pix_g  = per_img_rgb888[15:8];
  assign pix_b  = per_img_rgb888[7:0];
  assign rise   = per_frame_vsync & ~vs1_q;
  assign fall   = vs1_q & ~per_frame_vsync;
  assign pix_ok = per_frame_vsync & per_frame_href & per_frame_clken;

  always_comb begin
    sum_r_d = rise ? '0 : sum_r_q;
    sum_g_d = rise ? '0 : sum_g_q;
    sum_b_d = rise ? '0 : sum_b_q;
    if (pix_ok) begin
      sum_r_d = sum_r_d + SUM_W'(pix_r);
      sum_g_d = sum_g_d + SUM_W'(pix_g);
      sum_b_d = sum_b_d + SUM_W'(pix_b);
    end
  end

  vip_seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (SUM_W),
    .Q_W   (GAIN_W),
    .Q_MAX (GAIN_MAX)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_num),
    .divisor  (div_den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_num      = {sum_g_q, {GAIN_FRAC{1'b0}}};
    div_den      = sum_r_q;
    snap_g_d     = snap_g_q;
    snap_b_d     = snap_b_q;
    qr_d         = qr_q;
    shadow_r_d   = shadow_r_q;
    shadow_b_d   = shadow_b_q;
    pend_d       = pend_q;
    gain_r_d     = gain_r_q;
    gain_b_d     = gain_b_q;
    gain_valid_d = 1'b0;
    if (rise && pend_q) begin
      gain_r_d     = shadow_r_q;
      gain_b_d     = shadow_b_q;
      gain_valid_d = 1'b1;
      pend_d       = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (fall && !div_busy) begin
          div_start = 1'b1;
          snap_g_d  = sum_g_q;
          snap_b_d  = sum_b_q;
          state_d   = DIV_R;
        end
      end
      DIV_R: begin
        div_num = {snap_g_q, {GAIN_FRAC{1'b0}}};
        div_den = snap_b_q;
        if (div_done) begin
          qr_d      = div_q;
          div_start = 1'b1;
          state_d   = DIV_B;
        end
      end
      DIV_B: begin
        if (div_done) state_d = LOAD;
      end
      LOAD: begin
        shadow_r_d = qr_q;
        shadow_b_d = div_q;
        pend_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gr    = awb_en ? gain_r_q : UNITY;
    gb    = awb_en ? gain_b_q : UNITY;
    pr_d  = PW'(pix_r) * PW'(gr);
    pb_d  = PW'(pix_b) * PW'(gb);
    r_sh  = pr_q >> GAIN_FRAC;
    b_sh  = pb_q >> GAIN_FRAC;
    r_out = (|r_sh[PW-1:8]) ? 8'hff : r_sh[7:0];
    b_out = (|b_sh[PW-1:8]) ? 8'hff : b_sh[7:0];
    post_img_d = hs1_q ? {r_out, g1_q, b_out} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sum_r_q      <= '0;
      sum_g_q      <= '0;
      sum_b_q      <= '0;
      snap_g_q     <= '0;
      snap_b_q     <= '0;
      qr_q         <= UNITY;
      shadow_r_q   <= UNITY;
      shadow_b_q   <= UNITY;
      pend_q       <= 1'b0;
      gain_r_q     <= UNITY;
      gain_b_q     <= UNITY;
      gain_valid_q <= 1'b0;
      vs1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      ce1_q        <= 1'b0;
      vs2_q        <= 1'b0;
      hs2_q        <= 1'b0;
      ce2_q        <= 1'b0;
      pr_q         <= '0;
      pb_q         <= '0;
      g1_q         <= '0;
      post_img_q   <= '0;
    end else begin
      state_q      <= state_d;
      sum_r_q      <= sum_r_d;
      sum_g_q      <= sum_g_d;
      sum_b_q      <= sum_b_d;
      snap_g_q     <= snap_g_d;
      snap_b_q     <= snap_b_d;
      qr_q         <= qr_d;
      shadow_r_q   <= shadow_r_d;
      shadow_b_q   <= shadow_b_d;
      pend_q       <= pend_d;
      gain_r_q     <= gain_r_d;
      gain_b_q     <= gain_b_d;
      gain_valid_q <= gain_valid_d;
      vs1_q        <= per_frame_vsync;
      hs1_q        <= per_frame_href;
      ce1_q        <= per_frame_clken;
      vs2_q        <= vs1_q;
      hs2_q        <= hs1_q;
      ce2_q        <= ce1_q;
      pr_q         <= pr_d;
      pb_q         <= pb_d;
      g1_q         <= pix_g;
      post_img_q   <= post_img_d;
    end
  end

  assign post_frame_vsync = vs2_q;
  assign post_frame_href  = hs2_q;
  assign post_frame_clken = ce2_q;
  assign post_img_rgb888  = post_img_q;
  assign gain_r           = gain_r_q;
  assign gain_b           = gain_b_q;
  assign gain_valid       = gain_valid_q;

endmodule
